// File: rtl/chip_frame_decoder_if.sv
// Link lines into the frame decoder plus its decoded-frame results.
// master drives the link (controller side); slave is the decoder.
interface chip_frame_decoder_if #(
    parameter int CNT_W = 16
);
    logic             link_rst;
    logic             link_clk;
    logic             link_data;
    logic             frame_valid;
    logic             frame_err;
    logic [2:0]       rx_addr;
    logic [7:0]       rx_level;
    logic [63:0]      dac_regs;
    logic             chip_in_reset;
    logic [CNT_W-1:0] frame_count;

    modport master (
        output link_rst, link_clk, link_data,
        input  frame_valid, frame_err, rx_addr, rx_level, dac_regs,
               chip_in_reset, frame_count
    );

    modport slave (
        input  link_rst, link_clk, link_data,
        output frame_valid, frame_err, rx_addr, rx_level, dac_regs,
               chip_in_reset, frame_count
    );
endinterface

// File: rtl/chip_frame_decoder.sv
// Receive side of the serial DAC-programming link: oversamples the link,
// decodes start/addr[3]/level[8]/stop frames into an 8-entry shadow DAC file.
//
// state | meaning
// IDLE  | waiting for a 1 (arm) then a 0 (start bit)
// ADDR  | collecting 3 address bits, LSB first
// LEVEL | collecting 8 level bits, LSB first
// STOP  | expecting the stop bit (1 = good frame, 0 = framing error)
module chip_frame_decoder #(
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CNT_W          = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    chip_frame_decoder_if.slave link
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ADDR, LEVEL, STOP} state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic [1:0]       data_sync;
    logic [2:0]       clk_sync;
    logic             armed;
    logic [2:0]       idx;
    logic [2:0]       addr;
    logic [7:0]       level;
    logic [TMO_W-1:0] tmo_cnt;
    logic             frame_valid;
    logic             frame_err;
    logic [2:0]       rx_addr;
    logic [7:0]       rx_level;
    logic [7:0]       dac [8];
    logic             chip_in_reset;
    logic [CNT_W-1:0] frame_count;

    logic fall_evt;
    logic r;
    logic d;

    // clk_sync[2] is the previous synchronised value, used for edge detection
    assign fall_evt = clk_sync[2] & ~clk_sync[1];
    assign r        = rst_sync[1];
    assign d        = data_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rst_sync      <= '0;
            data_sync     <= '0;
            clk_sync      <= '0;
            armed         <= 1'b0;
            idx           <= '0;
            addr          <= '0;
            level         <= '0;
            tmo_cnt       <= TMO_LOAD;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            rx_addr       <= '0;
            rx_level      <= '0;
            for (int i = 0; i < 8; i++) dac[i] <= '0;
            chip_in_reset <= 1'b1;
            frame_count   <= '0;
        end else begin
            rst_sync    <= {rst_sync[0], link.link_rst};
            data_sync   <= {data_sync[0], link.link_data};
            clk_sync    <= {clk_sync[1:0], link.link_clk};
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (state == IDLE || fall_evt)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (fall_evt) begin
                if (!r) begin
                    // link reset wins over any frame in flight, silently
                    chip_in_reset <= 1'b1;
                    for (int i = 0; i < 8; i++) dac[i] <= '0;
                    state         <= IDLE;
                    armed         <= 1'b0;
                end else begin
                    chip_in_reset <= 1'b0;
                    case (state)
                        IDLE: begin
                            if (d) begin
                                armed <= 1'b1;
                            end else if (armed) begin
                                state <= ADDR;
                                idx   <= '0;
                            end
                        end
                        ADDR: begin
                            addr <= {d, addr[2:1]};
                            if (idx == 3'd2) begin
                                state <= LEVEL;
                                idx   <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                        LEVEL: begin
                            level <= {d, level[7:1]};
                            if (idx == 3'd7) begin
                                state <= STOP;
                                idx   <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                        STOP: begin
                            state <= IDLE;
                            if (d) begin
                                frame_valid <= 1'b1;
                                rx_addr     <= addr;
                                rx_level    <= level;
                                dac[addr]   <= level;
                                armed       <= 1'b1;
                                if (frame_count != '1)
                                    frame_count <= frame_count + 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (state != IDLE && tmo_cnt == '0) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                armed     <= 1'b0;
            end
        end
    end

    assign link.frame_valid   = frame_valid;
    assign link.frame_err     = frame_err;
    assign link.rx_addr       = rx_addr;
    assign link.rx_level      = rx_level;
    assign link.chip_in_reset = chip_in_reset;
    assign link.frame_count   = frame_count;

    for (genvar g = 0; g < 8; g++) begin : g_dac
        assign link.dac_regs[8*g +: 8] = dac[g];
    end
endmodule
